// File: rtl/expr_sequencer.sv
// Moore controller sequencing the expression-solver datapath through ((A*X)+B)*X + C.
// Optional macro OVF_ABORT_EN: an ALU overflow cuts the sequence short and jumps to DONE.
module expr_sequencer #(
    parameter logic H_ADD = 1'b0,
    parameter logic H_MUL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       zero,
    input  logic       overflow,
    output logic       LX,
    output logic       LS,
    output logic       LH,
    output logic       H,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       busy,
    output logic       done,
    output logic       ovf_flag,
    output logic       is_zero
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_MUL_AX = 3'd2,
        S_ADD_B  = 3'd3,
        S_MUL_X  = 3'd4,
        S_ADD_C  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t state_q;
    logic   ovf_flag_q;
    logic   is_zero_q;
    logic   alu_step;
    logic   abort_step;

    assign alu_step = (state_q == S_MUL_AX) || (state_q == S_ADD_B) ||
                      (state_q == S_MUL_X)  || (state_q == S_ADD_C);

`ifdef OVF_ABORT_EN
    assign abort_step = overflow;
`else
    assign abort_step = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ovf_flag_q <= 1'b0;
            is_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD_X;
                        ovf_flag_q <= 1'b0;
                    end
                end
                S_LOAD_X: state_q <= S_MUL_AX;
                S_MUL_AX: state_q <= abort_step ? S_DONE : S_ADD_B;
                S_ADD_B:  state_q <= abort_step ? S_DONE : S_MUL_X;
                S_MUL_X:  state_q <= abort_step ? S_DONE : S_ADD_C;
                S_ADD_C:  state_q <= S_DONE;
                S_DONE: begin
                    state_q   <= S_IDLE;
                    is_zero_q <= zero;
                end
                default:  state_q <= S_IDLE;
            endcase
            // Sticky: only the accepted start in IDLE clears it, so no conflict here.
            if (alu_step && overflow) begin
                ovf_flag_q <= 1'b1;
            end
        end
    end

    always_comb begin
        LX   = 1'b0;
        LS   = 1'b0;
        LH   = 1'b0;
        H    = H_ADD;
        M0   = 2'b00;
        M1   = 2'b00;
        M2   = 2'b00;
        busy = 1'b1;
        done = 1'b0;
        case (state_q)
            S_LOAD_X: LX = 1'b1;
            S_MUL_AX: begin
                M0 = 2'b01;
                H  = H_MUL;
                LS = 1'b1;
            end
            S_ADD_B: begin
                M0 = 2'b10;
                M2 = 2'b10;
                LS = 1'b1;
            end
            S_MUL_X: begin
                M1 = 2'b10;
                H  = H_MUL;
                LS = 1'b1;
            end
            S_ADD_C: begin
                M0 = 2'b11;
                M2 = 2'b10;
                LH = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign ovf_flag = ovf_flag_q;
    assign is_zero  = is_zero_q;

endmodule
